nios_debug_slave_cmd_sysclk: RTL and testbench

//  System-clock half of the multi-channel Nios II debug slave. It synchronises Update-DR/Update-IR toggles

---
 rtl/nios_debug_slave_cmd_sysclk.sv | 163 ++++++++++++++++
 tb/tb_nios_debug_slave_cmd_sysclk.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_debug_slave_cmd_sysclk.sv
// System-clock side of the Nios II debug slave: synchronises Update-DR/IR toggles, queues
// {ir, sr} commands in a FIFO and emits per-channel action pulses as commands are consumed.
module nios_debug_slave_cmd_sysclk #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACT_BIT     = 35
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [IR_W-1:0]                    ir_in,
  input  logic [DATA_W-1:0]                  sr,
  input  logic                               udr_toggle,
  input  logic                               uir_toggle,
  input  logic                               cmd_ready,
  input  logic                               ovf_clr,
  output logic                               cmd_valid,
  output logic [IR_W-1:0]                    cmd_ir,
  output logic [DATA_W-1:0]                  cmd_data,
  output logic [DATA_W-1:0]                  jdo,
  output logic [(1<<IR_W)-1:0]               take_action,
  output logic [(1<<IR_W)-1:0]               take_no_action,
  output logic                               ir_change,
  output logic                               overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned NCH     = 1 << IR_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);
  localparam int unsigned CMD_W   = IR_W + DATA_W;

  // Toggle synchronisers and edge history
  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_prev_q, uir_prev_q;
  logic                   udr_evt_q, uir_evt_q;
  logic [PRIME_W-1:0]     prime_q;
  logic                   priming;

  assign priming = (prime_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_prev_q <= 1'b0;
      uir_prev_q <= 1'b0;
      udr_evt_q  <= 1'b0;
      uir_evt_q  <= 1'b0;
      prime_q    <= PRIME_W'(SYNC_STAGES + 1);
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], udr_toggle};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], uir_toggle};
      udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      // History keeps tracking while priming so levels present at release never look like edges
      udr_evt_q  <= ~priming & (udr_sync_q[SYNC_STAGES-1] ^ udr_prev_q);
      uir_evt_q  <= ~priming & (uir_sync_q[SYNC_STAGES-1] ^ uir_prev_q);
      if (priming) begin
        prime_q <= prime_q - PRIME_W'(1);
      end
    end
  end

  // Command FIFO
  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full, pop, push_ok, drop;

  assign full      = (level_q == LVL_W'(FIFO_DEPTH));
  assign cmd_valid = (level_q != '0);
  assign pop       = cmd_valid & cmd_ready;
  // A simultaneous pop frees the slot, so a push on a full FIFO only drops without one
  assign push_ok   = udr_evt_q & (~full | pop);
  assign drop      = udr_evt_q & full & ~pop;

  assign {cmd_ir, cmd_data} = mem_q[rptr_q];
  assign fifo_level         = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= {ir_in, sr};
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      level_q <= level_d;
    end
  end

  // Consumed-command outputs
  logic [DATA_W-1:0] jdo_q, jdo_d;
  logic [NCH-1:0]    take_action_q, take_action_d;
  logic [NCH-1:0]    take_no_action_q, take_no_action_d;
  logic              overflow_q, overflow_d;
  logic              ir_change_q;

  always_comb begin
    jdo_d            = jdo_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    if (pop) begin
      jdo_d = cmd_data;
      if (cmd_data[ACT_BIT]) begin
        take_action_d[cmd_ir] = 1'b1;
      end else begin
        take_no_action_d[cmd_ir] = 1'b1;
      end
    end
    // A fresh overflow beats a clear in the same cycle
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overflow_q       <= 1'b0;
      ir_change_q      <= 1'b0;
    end else begin
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overflow_q       <= overflow_d;
      ir_change_q      <= uir_evt_q;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign overflow       = overflow_q;
  assign ir_change      = ir_change_q;

endmodule

// File: tb/tb_nios_debug_slave_cmd_sysclk.sv
// Bench for nios_debug_slave_cmd_sysclk: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the command stream.
module tb_nios_debug_slave_cmd_sysclk;
  localparam int unsigned DATA_W = 38;
  localparam int unsigned IR_W   = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LAT    = 4;  // edges from toggle sample to FIFO write, inclusive

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset, udr_toggle, uir_toggle, cmd_ready, ovf_clr;
  logic [IR_W-1:0]   ir_in;
  logic [DATA_W-1:0] sr;
  logic              cmd_valid, ir_change, overflow;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data, jdo;
  logic [3:0]        take_action, take_no_action;
  logic [2:0]        fifo_level;

  nios_debug_slave_cmd_sysclk dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .sr             (sr),
    .udr_toggle     (udr_toggle),
    .uir_toggle     (uir_toggle),
    .cmd_ready      (cmd_ready),
    .ovf_clr        (ovf_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_change      (ir_change),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model state
  cmd_t              q[$];
  logic [DATA_W-1:0] exp_jdo;
  logic [3:0]        exp_ta, exp_tna;
  logic              exp_irc, exp_ovf;
  int                udr_cnt, uir_cnt;
  int                n_checks = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] saved [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cmd_valid", 64'(cmd_valid), 64'(q.size() > 0));
    chk("fifo_level", 64'(fifo_level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    chk("take_action", 64'(take_action), 64'(exp_ta));
    chk("take_no_action", 64'(take_no_action), 64'(exp_tna));
    chk("ir_change", 64'(ir_change), 64'(exp_irc));
    chk("jdo", 64'(jdo), 64'(exp_jdo));
    if (q.size() > 0) begin
      chk("cmd_ir", 64'(cmd_ir), 64'(q[0].ir));
      chk("cmd_data", 64'(cmd_data), 64'(q[0].data));
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    int   sz;
    bit   pop, push, drop;
    cmd_t c;
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_jdo = '0; exp_ta = '0; exp_tna = '0; exp_irc = 1'b0; exp_ovf = 1'b0;
      udr_cnt = 0; uir_cnt = 0;
    end else begin
      sz      = q.size();
      pop     = cmd_ready && sz > 0;
      push    = (udr_cnt == 1);
      exp_irc = (uir_cnt == 1);
      if (udr_cnt > 0) udr_cnt--;
      if (uir_cnt > 0) uir_cnt--;
      exp_ta  = '0;
      exp_tna = '0;
      drop    = 1'b0;
      if (pop) begin
        c       = q.pop_front();
        exp_jdo = c.data;
        if (c.data[35]) exp_ta[c.ir] = 1'b1;
        else exp_tna[c.ir] = 1'b1;
      end
      if (push) begin
        if (sz == DEPTH && !pop) drop = 1'b1;
        else q.push_back(cmd_t'{ir: ir_in, data: sr});
      end
      if (drop) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic flip_udr(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
    ir_in      = ir;
    sr         = d;
    udr_toggle = ~udr_toggle;
    udr_cnt    = LAT;
  endtask

  task automatic flip_uir();
    uir_toggle = ~uir_toggle;
    uir_cnt    = LAT;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(LAT + 1);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data(input bit act);
    logic [DATA_W-1:0] d;
    d     = DATA_W'({$urandom(), $urandom()});
    d[35] = act;
    return d;
  endfunction

  initial begin
    reset = 1'b1; udr_toggle = 1'b0; uir_toggle = 1'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0;
    udr_cnt = 0; uir_cnt = 0;
    exp_jdo = '0; exp_ta = '0; exp_tna = '0; exp_irc = 1'b0; exp_ovf = 1'b0;
    #1;
    do_reset();
    chk("reset_jdo", 64'(jdo), 64'h0);
    chk("reset_level", 64'(fifo_level), 64'h0);

    // Single action command on channel 2
    cmd_ready = 1'b1;
    flip_udr(2'd2, rnd_data(1'b1));
    steps(4);
    chk("t1_valid_c3", 64'(cmd_valid), 64'h1);
    step();
    chk("t1_take_action", 64'(take_action), 64'h4);
    chk("t1_jdo", 64'(jdo), 64'(sr));
    step();
    chk("t1_pulse_end", 64'(take_action), 64'h0);

    // No-action command on channel 0
    flip_udr(2'd0, rnd_data(1'b0));
    steps(5);
    chk("t2_take_no_action", 64'(take_no_action), 64'h1);
    chk("t2_take_action", 64'(take_action), 64'h0);
    steps(2);

    // Overflow: five commands with no consumer
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saved[i] = rnd_data(1'(i & 1));
      flip_udr(2'(i), saved[i]);
      steps(LAT);
    end
    chk("t3_level", 64'(fifo_level), 64'h4);
    chk("t3_overflow", 64'(overflow), 64'h1);
    cmd_ready = 1'b1;
    steps(6);
    chk("t3_last_drained", 64'(jdo), 64'(saved[3]));
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'h0);

    // Full FIFO with a pop in the push cycle, then overflow racing ovf_clr
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flip_udr(2'(i), rnd_data(1'b1));
      steps(LAT);
    end
    flip_udr(2'd3, rnd_data(1'b0));
    steps(LAT - 1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("t5_level", 64'(fifo_level), 64'h4);
    chk("t5_no_overflow", 64'(overflow), 64'h0);
    step();
    flip_udr(2'd1, rnd_data(1'b1));
    steps(LAT - 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t5_ovf_wins", 64'(overflow), 64'h1);
    cmd_ready = 1'b1;
    steps(6);

    // Toggles held high through reset release must not create events
    cmd_ready  = 1'b0;
    udr_toggle = 1'b1;
    uir_toggle = 1'b1;
    do_reset();
    steps(6);
    chk("t4_no_cmd", 64'(cmd_valid), 64'h0);
    flip_udr(2'd1, rnd_data(1'b1));
    steps(LAT + 2);
    chk("t4_one_cmd", 64'(fifo_level), 64'h1);

    // Update-IR pulse, then reset with entries queued
    flip_uir();
    steps(3);
    chk("t6_irc_early", 64'(ir_change), 64'h0);
    step();
    chk("t6_irc_c3", 64'(ir_change), 64'h1);
    step();
    chk("t6_irc_single", 64'(ir_change), 64'h0);
    flip_udr(2'd3, rnd_data(1'b0));
    steps(LAT);
    chk("t6_two_queued", 64'(fifo_level), 64'h2);
    cmd_ready = 1'b1;
    do_reset();
    chk("t6_flushed", 64'(fifo_level), 64'h0);
    chk("t6_no_pulse", 64'(take_action | take_no_action), 64'h0);

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      flip_udr(2'($urandom_range(0, 3)), rnd_data(1'($urandom_range(0, 1))));
      for (int s = 0; s < int'(LAT) + int'($urandom_range(0, 3)); s++) begin
        cmd_ready = ($urandom_range(0, 2) == 0);
        ovf_clr   = ($urandom_range(0, 9) == 0);
        if (uir_cnt == 0 && $urandom_range(0, 5) == 0) flip_uir();
        step();
      end
      ovf_clr = 1'b0;
    end
    cmd_ready = 1'b1;
    steps(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
